// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master between NUM_REQ register writers.
// Each frame is SLAVE_ADDR, reg_addr, byte1[, byte2], STOP; every wait is bounded by TIMEOUT_CYC.
module i2c_bus_arbiter #(
    parameter int          NUM_REQ     = 2,
    parameter logic [7:0]  SLAVE_ADDR  = 8'hAA,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [8*NUM_REQ-1:0]    req_reg_addr,
    input  logic [16*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_len,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    err,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    input  logic                    ready,
    output logic                    start,
    output logic                    stop,
    output logic                    i2c_en,
    output logic [7:0]              tx_data,
    input  logic                    tx_done
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {
        IDLE, LATCH, WAIT_RDY, ISSUE, WAIT_DONE, STOP, WAIT_STOP, ACK
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [1:0]      idx;
    logic [TW-1:0]   timer;
    logic [7:0]      reg_q;
    logic [15:0]     data_q;
    logic            len_q;
    logic            aborting;

    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   jj;
    int              jint;
    logic [7:0]      sel_reg;
    logic [15:0]     sel_data;
    logic            sel_len;
    logic [7:0]      cur_byte;
    logic            last_byte;
    logic            timed_out;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        jint   = 0;
        jj     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            jint = int'(ptr) + i;
            if (jint >= NUM_REQ) jint = jint - NUM_REQ;
            jj = IW'(jint);
            if (req[jj]) begin
                found  = 1'b1;
                winner = jj;
            end
        end
    end

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        sel_len  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                sel_reg  = req_reg_addr[8*i +: 8];
                sel_data = req_data[16*i +: 16];
                sel_len  = req_len[i];
            end
        end
    end

    always_comb begin
        case (idx)
            2'd0:    cur_byte = SLAVE_ADDR;
            2'd1:    cur_byte = reg_q;
            2'd2:    cur_byte = data_q[15:8];
            default: cur_byte = data_q[7:0];
        endcase
    end

    assign last_byte = (idx == (len_q ? 2'd3 : 2'd2));
    assign timed_out = (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            idx      <= '0;
            timer    <= '0;
            reg_q    <= '0;
            data_q   <= '0;
            len_q    <= 1'b0;
            aborting <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            i2c_en   <= 1'b0;
            tx_data  <= '0;
        end else begin
            i2c_en <= 1'b0;
            start  <= 1'b0;
            stop   <= 1'b0;
            ack    <= '0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= winner;
                        grant <= ONE_HOT0 << winner;
                        busy  <= 1'b1;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    reg_q    <= sel_reg;
                    data_q   <= sel_data;
                    len_q    <= sel_len;
                    idx      <= '0;
                    aborting <= 1'b0;
                    timer    <= '0;
                    state    <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (ready) begin
                        timer   <= '0;
                        i2c_en  <= 1'b1;
                        tx_data <= cur_byte;
                        start   <= (idx == 2'd0);
                        state   <= ISSUE;
                    end else if (timed_out) begin
                        timer <= '0;
                        ack   <= grant;
                        err   <= 1'b1;
                        state <= ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        timer <= '0;
                        if (last_byte) begin
                            state <= STOP;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= WAIT_RDY;
                        end
                    end else if (timed_out) begin
                        // Stalled byte: release the bus even though the master is not ready.
                        timer    <= '0;
                        i2c_en   <= 1'b1;
                        stop     <= 1'b1;
                        aborting <= 1'b1;
                        state    <= WAIT_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (ready) begin
                        timer  <= '0;
                        i2c_en <= 1'b1;
                        stop   <= 1'b1;
                        state  <= WAIT_STOP;
                    end else if (timed_out) begin
                        timer <= '0;
                        ack   <= grant;
                        err   <= 1'b1;
                        state <= ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_STOP: begin
                    if (ready || aborting || timed_out) begin
                        timer <= '0;
                        ack   <= grant;
                        err   <= aborting || !ready;
                        state <= ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    timer <= '0;
                    if (owner == IW'(NUM_REQ - 1)) ptr <= '0;
                    else                           ptr <= owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: stimulus queues expected strobes/acks, a monitor pops and compares.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_reg_addr;
    logic [31:0] req_data;
    logic [1:0]  req_len;
    logic [1:0]  ack;
    logic        err;
    logic [1:0]  grant;
    logic        busy;
    logic        ready;
    logic        start;
    logic        stop;
    logic        i2c_en;
    logic [7:0]  tx_data;
    logic        tx_done;

    i2c_bus_arbiter #(.NUM_REQ(2), .SLAVE_ADDR(8'hAA), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .req(req), .req_reg_addr(req_reg_addr),
        .req_data(req_data), .req_len(req_len), .ack(ack), .err(err),
        .grant(grant), .busy(busy), .ready(ready), .start(start), .stop(stop),
        .i2c_en(i2c_en), .tx_data(tx_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [7:0] data;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [2:0] exp_ack[$];
    int         total = 0;
    int         bad = 0;
    int         data_strobes = 0;
    logic       done_en;
    logic [1:0] pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got nothing expected event", name);
    endtask

    task automatic push_frame(input logic [7:0] ra, input logic [15:0] d, input logic len,
                              input logic [1:0] who);
        exp_cmd.push_back({1'b1, 1'b0, 8'hAA});
        exp_cmd.push_back({1'b0, 1'b0, ra});
        exp_cmd.push_back({1'b0, 1'b0, d[15:8]});
        if (len) exp_cmd.push_back({1'b0, 1'b0, d[7:0]});
        exp_cmd.push_back({1'b0, 1'b1, 8'h00});
        exp_ack.push_back({1'b0, who});
    endtask

    task automatic wait_ack(input string name, input int maxc, output logic [1:0] seen);
        seen = 2'b00;
        for (int n = 0; n < maxc; n++) begin
            @(posedge clk); #1;
            if (|ack) begin
                seen = ack;
                return;
            end
        end
        fail(name);
    endtask

    task automatic wait_strobe(input string name, input int maxc);
        for (int n = 0; n < maxc; n++) begin
            @(posedge clk); #1;
            if (i2c_en) return;
        end
        fail(name);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Master model: tx_done pulses two cycles after each byte strobe.
    initial begin
        pend    = 2'b00;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = pend[1];
            pend    = {pend[0], i2c_en & ~stop & done_en};
        end
    end

    // Monitor
    initial begin
        cmd_t       e;
        logic [2:0] ea;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (i2c_en) begin
                    if (!stop) data_strobes++;
                    if (exp_cmd.size() == 0) begin
                        check("unexpected strobe", {22'b0, start, stop, tx_data}, 32'h0);
                        if ({start, stop, tx_data} == 10'h0) fail("unexpected strobe");
                    end else begin
                        e = exp_cmd.pop_front();
                        check("strobe start/stop", {30'b0, start, stop}, {30'b0, e.start, e.stop});
                        if (!e.stop) check("strobe byte", {24'b0, tx_data}, {24'b0, e.data});
                    end
                end
                if (|ack || err) begin
                    if (exp_ack.size() == 0) begin
                        check("unexpected ack", {29'b0, err, ack}, 32'h0);
                    end else begin
                        ea = exp_ack.pop_front();
                        check("ack/err", {29'b0, err, ack}, {29'b0, ea});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seen;
        int         lat;
        int         cnt;
        reset        = 1'b1;
        req          = '0;
        req_reg_addr = '0;
        req_data     = '0;
        req_len      = '0;
        ready        = 1'b1;
        done_en      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack/err/grant", {27'b0, ack, err, grant}, 32'h0);
        check("reset busy/start/stop/en", {28'b0, busy, start, stop, i2c_en}, 32'h0);
        check("reset tx_data", {24'b0, tx_data}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-byte write from requester 0
        req_reg_addr[7:0] = 8'h00;
        req_data[15:0]    = 16'h40C8;
        req_len[0]        = 1'b1;
        push_frame(8'h00, 16'h40C8, 1'b1, 2'b01);
        req[0] = 1'b1;
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            lat++;
            if (i2c_en) break;
        end
        check("first strobe latency", 32'(lat), 32'd3);
        wait_ack("A ack", 200, seen);
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("A busy after ack", {31'b0, busy}, 32'h0);

        // One-byte write from requester 1
        data_strobes = 0;
        req_reg_addr[15:8] = 8'h01;
        req_data[31:16]    = 16'h0500;
        req_len[1]         = 1'b0;
        push_frame(8'h01, 16'h0500, 1'b0, 2'b10);
        req[1] = 1'b1;
        wait_ack("B ack", 200, seen);
        req[1] = 1'b0;
        @(posedge clk); #1;
        check("B data strobes", 32'(data_strobes), 32'd3);

        // Both requesting: must alternate starting from 0
        pulse_reset();
        req_reg_addr = {8'h20, 8'h10};
        req_data     = {16'h3344, 16'h1122};
        req_len      = 2'b10;
        push_frame(8'h10, 16'h1122, 1'b0, 2'b01);
        push_frame(8'h20, 16'h3344, 1'b1, 2'b10);
        push_frame(8'h10, 16'h1122, 1'b0, 2'b01);
        req = 2'b11;
        wait_ack("C ack1", 200, seen);
        check("C first grant", {30'b0, seen}, 32'h1);
        wait_ack("C ack2", 200, seen);
        check("C second grant", {30'b0, seen}, 32'h2);
        wait_ack("C ack3", 200, seen);
        check("C third grant", {30'b0, seen}, 32'h1);
        req = 2'b00;
        @(posedge clk); #1;

        // Master not ready for 50 cycles before second byte
        req_reg_addr[7:0] = 8'h07;
        req_data[15:0]    = 16'h9A00;
        req_len[0]        = 1'b0;
        push_frame(8'h07, 16'h9A00, 1'b0, 2'b01);
        req[0] = 1'b1;
        wait_strobe("D first strobe", 20);
        ready = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (i2c_en) cnt++;
        end
        check("D strobes while not ready", 32'(cnt), 32'd0);
        ready = 1'b1;
        wait_ack("D ack", 200, seen);
        req[0] = 1'b0;
        @(posedge clk); #1;

        // tx_done never returns: forced stop then ack with err
        done_en = 1'b0;
        req_reg_addr[7:0] = 8'h33;
        req_data[15:0]    = 16'h5500;
        exp_cmd.push_back({1'b1, 1'b0, 8'hAA});
        exp_cmd.push_back({1'b0, 1'b1, 8'h00});
        exp_ack.push_back(3'b101);
        req[0] = 1'b1;
        wait_ack("E ack", 300, seen);
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("E busy after abort", {31'b0, busy}, 32'h0);

        // Reset in WAIT_DONE, then a fresh frame
        exp_cmd.push_back({1'b1, 1'b0, 8'hAA});
        req[0] = 1'b1;
        wait_strobe("F first strobe", 20);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("F reset ack/err/grant", {27'b0, ack, err, grant}, 32'h0);
        check("F reset busy/start/stop/en", {28'b0, busy, start, stop, i2c_en}, 32'h0);
        check("F reset tx_data", {24'b0, tx_data}, 32'h0);
        check("F queues before restart", 32'(exp_cmd.size() + exp_ack.size()), 32'd0);
        reset   = 1'b0;
        done_en = 1'b1;
        push_frame(8'h33, 16'h5500, 1'b0, 2'b01);
        wait_ack("F ack", 200, seen);
        req[0] = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("queues drained", 32'(exp_cmd.size() + exp_ack.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
